// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned Width = 32;
  localparam int unsigned Iter  = Width;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  // Booth recode of {lo[0], q}
  localparam logic [1:0] BoothAdd = 2'b01;
  localparam logic [1:0] BoothSub = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: sign-extended add/sub of the multiplicand into the
// high half, then a one-bit arithmetic right shift of the whole product register.
module booth_step
  import multdiv_pkg::*;
#(
  parameter int unsigned W = Width
) (
  input  logic [2*W:0] p_i,
  input  logic [W-1:0] a_i,
  output logic [2*W:0] p_o
);

  logic [W:0] hi_ext;
  logic [W:0] a_ext;
  logic [W:0] sum;

  always_comb begin
    hi_ext = {p_i[2*W], p_i[2*W:W+1]};
    a_ext  = {a_i[W-1], a_i};
    unique case (p_i[1:0])
      BoothAdd: sum = hi_ext + a_ext;
      BoothSub: sum = hi_ext - a_ext;
      default:  sum = hi_ext;
    endcase
    // Keeping the 33-bit sum makes the shift sign-correct even for A = -2^31
    p_o = {sum, p_i[W:1]};
  end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring) unit.
// Define MULTDIV_DIV_EN to build the divider; otherwise DIV completes with exception set.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = Width,
  parameter int unsigned ITER  = Iter,
  parameter int unsigned CNT_W = $clog2(ITER) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(ITER - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic [2*WIDTH:0]   mul_p;

  booth_step #(
    .W (WIDTH)
  ) u_booth_step (
    .p_i (p_q),
    .a_i (a_q),
    .p_o (mul_p)
  );

`ifdef MULTDIV_DIV_EN
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, rem_nx;
  logic [2*WIDTH:0] div_p;

  // p holds {remainder[WIDTH:0], quotient[WIDTH-1:0]}; a_q holds |B|
  always_comb begin
    abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    rem_sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    rem_nx = p_q[2*WIDTH] ? rem_sh + {1'b0, a_q} : rem_sh - {1'b0, a_q};
    div_p  = {rem_nx, p_q[WIDTH-2:0], ~rem_nx[WIDTH]};
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    res_d    = res_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
    neg_d    = neg_q;
    dz_d     = dz_q;
`endif

    unique case (state_q)
      StIdle: ;
      StMul: begin
        p_d   = mul_p;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CntLast) state_d = StDone;
      end
      StDiv: begin
`ifdef MULTDIV_DIV_EN
        p_d   = div_p;
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CntLast) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        rdy_d   = 1'b1;
        if (is_div_q) begin
`ifdef MULTDIV_DIV_EN
          // Only the quotient is exported, so no remainder fix-up is needed
          res_d = dz_q ? '0 : (neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]);
          exc_d = dz_q;
`else
          res_d = '0;
          exc_d = 1'b1;
`endif
        end else begin
          res_d = p_q[WIDTH:1];
          exc_d = p_q[2*WIDTH:WIDTH+1] != {WIDTH{p_q[WIDTH]}};
        end
      end
    endcase

    // A new start always wins, aborting whatever was in flight
    if (ctrl_MULT) begin
      state_d  = StMul;
      cnt_d    = '0;
      p_d      = {{WIDTH{1'b0}}, data_operandB, 1'b0};
      a_d      = data_operandA;
      is_div_d = 1'b0;
      res_d    = res_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
    end else if (ctrl_DIV) begin
      state_d  = StDiv;
      cnt_d    = '0;
      is_div_d = 1'b1;
      res_d    = res_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
      p_d      = {{(WIDTH + 1){1'b0}}, abs_a};
      a_d      = abs_b;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_d     = data_operandB == '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      p_q      <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef MULTDIV_DIV_EN
      neg_q    <= neg_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed and randomized bench for multdiv_iter; divide expectations follow MULTDIV_DIV_EN.
module tb_multdiv_iter;

`ifdef MULTDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int passes = 0;
  int pulses;
  int first;
  logic [31:0] r;
  logic        e;

  multdiv_iter dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulses the start controls so exactly one rising edge (edge 0) samples them.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Watches n cycles; k-th sample follows edge k after the start.
  task automatic observe(input int n, output int np, output int fk, output logic [31:0] rr,
                         output logic ee);
    np = 0;
    fk = 0;
    rr = '0;
    ee = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        np++;
        if (fk == 0) begin
          fk = k;
          rr = data_result;
          ee = data_exception;
        end
      end
    end
  endtask

  task automatic do_op(input string tag, input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e);
    int np, fk;
    logic [31:0] rr;
    logic ee;
    start_op(m, d, a, b);
    observe(40, np, fk, rr, ee);
    check({tag, " rdy_count"}, 64'(np), 64'd1);
    check({tag, " rdy_edge"}, 64'(fk), 64'd33);
    check({tag, " result"}, 64'(rr), 64'(exp_r));
    check({tag, " exception"}, 64'(ee), 64'(exp_e));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] prod;

    repeat (2) @(negedge clock);
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    reset = 1'b0;

    do_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    @(negedge clock);
    check("hold result", 64'(data_result), 64'hFFFF_FFEB);

    // Reset mid-multiply aborts with no RDY and clears the held result
    start_op(1'b1, 1'b0, 32'd7, 32'd3);
    observe(9, pulses, first, r, e);
    check("pre-reset rdy_count", 64'(pulses), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset result", 64'(data_result), 64'd0);
    check("midreset exception", 64'(data_exception), 64'd0);
    check("midreset rdy", 64'(data_resultRDY), 64'd0);
    observe(40, pulses, first, r, e);
    check("post-reset rdy_count", 64'(pulses), 64'd0);
    check("post-reset result", 64'(data_result), 64'd0);

    do_op("mul ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    do_op("mul min*1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);

    do_op("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,
          DivEn ? 32'hFFFF_FFFD : 32'h0, !DivEn);
    do_op("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, DivEn ? 32'd14 : 32'd0, !DivEn);
    do_op("div 5/0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
    do_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          DivEn ? 32'h8000_0000 : 32'h0, !DivEn);

    // DIV restarting an in-flight MULT
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    observe(9, pulses, first, r, e);
    check("abort rdy_early", 64'(pulses), 64'd0);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    observe(40, pulses, first, r, e);
    check("abort rdy_count", 64'(pulses), 64'd1);
    check("abort rdy_edge", 64'(first), 64'd33);
    check("abort result", 64'(r), DivEn ? 64'd14 : 64'd0);
    check("abort exception", 64'(e), 64'(!DivEn));

    do_op("mult wins", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);
    do_op("div 10/2", 1'b0, 1'b1, 32'd10, 32'd2, DivEn ? 32'd5 : 32'd0, !DivEn);

    for (int i = 0; i < 8; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      if (i < 4) rb = rb >> 20;
      prod = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
      do_op($sformatf("rand mul %0h*%0h", ra, rb), 1'b1, 1'b0, ra, rb, prod[31:0],
            prod[63:32] != {32{prod[31]}});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
